logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, buffered bitwise logic unit: the successor to the fixed 32-bit NOR array in the datapath. Takes two WIDTH-bit operands and a 3-bit opcode under a valid/ready handshake, computes one of eight bitwise functions, and queues results with zero/all-ones flags in a DEPTH-entry output FIFO. Sits between the decode/register-read stage and writeback, decoupling result consumption from operand issue.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- DEPTH, 2, output FIFO entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit can accept a beat this cycle
- in_op  in  3  function select
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head this cycle
- out_result  out  WIDTH  head result
- out_zero  out  1  head result == 0
- out_ones  out  1  head result == all ones
- out_parity  out  1  XOR-reduce of head result (only with LOGIC_UNIT_PARITY_EN)
- occupancy  out  $clog2(DEPTH+1)  entries currently held

## Operation
- Opcodes: 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B), 100 ~(A&B), 101 ~(A^B), 110 A&~B, 111 A|~B.
- Push: in_valid && in_ready; result and flags computed from the in_* values that cycle and written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- in_ready = (occupancy != DEPTH); registered state only, no combinational path from out_ready. When full, a same-cycle pop does not open in_ready.
- out_valid = (occupancy != 0). When out_valid is 0, out_result, out_zero, out_ones, out_parity are driven 0.
- Head data stable while out_valid && !out_ready.
- in_valid with in_ready low: beat ignored, no state change; producer must hold.
- Flags are computed at push and stored with the entry (WIDTH+2 or WIDTH+3 bits per entry).

## Timing
- Reset (rst_n low, any time): occupancy=0, pointers=0, in_ready=1, out_valid=0, all data/flag outputs 0; entries in flight discarded. Deassertion is synchronised by the integrator; the block assumes clean release.
- Latency: beat accepted on edge N appears at head with out_valid=1 after edge N if FIFO was empty (visible in cycle N+1).
- Throughput: one beat per cycle sustained when out_ready held high.
- Full: after DEPTH pushes with no pop, in_ready=0 the following cycle; it returns to 1 the cycle after the first pop.
- Pointer wrap: index DEPTH-1 → 0, no bubble.

## Configuration
- LOGIC_UNIT_PARITY_EN defined: out_parity port exists; each entry stores parity = ^result computed at push; out_parity 0 when empty.
- Undefined: out_parity port and storage bit omitted; all other behaviour identical.

## Test plan
- Reset/idle: rst_n low then high, no input -> in_ready=1, out_valid=0, occupancy=0, out_result=0.
- All opcodes, WIDTH=32, A=0xF0F0_00FF, B=0xFF00_0F0F, out_ready=1 -> results 0xF000_000F, 0xFFF0_0FFF, 0x0FF0_0FF0, 0x000F_F000, 0x0FFF_FFF0, 0xF00F_F00F, 0x00F0_00F0, 0xF0FF_F0FF, each one cycle after its push.
- Flags: op 011 with A=B=0 -> result 0xFFFF_FFFF, out_ones=1, out_zero=0; op 000 with A=0x1234_5678, B=0 -> out_zero=1; with macro, A^B=0x0000_0007 -> out_parity=1.
- Backpressure/full, DEPTH=2: out_ready=0, push 0x1 then 0x2 (op 001, B=0) -> occupancy=2, in_ready=0, third beat 0x3 ignored; raise out_ready -> 0x1, 0x2 in order, then 0x3 accepted after in_ready reasserts.
- Simultaneous push/pop with wrap: occupancy=1, in_valid and out_ready high for 5 cycles -> occupancy stays 1, outputs in push order across pointer wrap.
- Reset mid-stream: occupancy=2, assert rst_n low asynchronously mid-cycle -> out_valid=0, in_ready=1 immediately; no stale entry appears after release.

Source files
------------

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Parametrised bitwise logic unit with a DEPTH-entry output FIFO.
//            Each accepted operand beat is reduced by one of eight bitwise
//            functions.  The result, its zero flag and its all-ones flag are
//            queued together so that the consumer is decoupled from issue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//   DEPTH      output FIFO entries (power of two, >= 2)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   unit can accept a beat this cycle (registered state only)
//   in_op      function select
//   in_a/in_b  operands
//   out_valid  FIFO head valid
//   out_ready  consumer takes head this cycle
//   out_result head result (0 when empty)
//   out_zero   head result == 0 (0 when empty)
//   out_ones   head result == all ones (0 when empty)
//   out_parity XOR-reduce of head result (0 when empty); present only when
//              LOGIC_UNIT_PARITY_EN is defined
//   occupancy  entries currently held
// Build option
//   LOGIC_UNIT_PARITY_EN : adds the out_parity port and a stored parity bit
// ============================================================================
module logic_unit_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic                       out_zero,
   output logic                       out_ones,
`ifdef LOGIC_UNIT_PARITY_EN
   output logic                       out_parity,
`endif
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_occ_w = $clog2(DEPTH+1);
`ifdef LOGIC_UNIT_PARITY_EN
   localparam int c_flag_w = 3;
`else
   localparam int c_flag_w = 2;
`endif
   localparam int c_entry_w = WIDTH + c_flag_w;
   localparam logic [c_occ_w-1:0] c_full = c_occ_w'(DEPTH);

   // Entry layout: [WIDTH-1:0] result, [WIDTH] zero, [WIDTH+1] ones,
   // [WIDTH+2] parity (parity build only).
   logic [c_entry_w-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_occ_w-1:0]   r_occ;

   logic [WIDTH-1:0]     w_result;
   logic [c_entry_w-1:0] w_entry;
   logic [c_entry_w-1:0] w_head;
   logic                 w_push;
   logic                 w_pop;

   // ---------------------------------------------------------------------
   // Function select
   // ---------------------------------------------------------------------
   always_comb begin
      w_result = '0;
      case (in_op)
         3'b000:  w_result = in_a & in_b;
         3'b001:  w_result = in_a | in_b;
         3'b010:  w_result = in_a ^ in_b;
         3'b011:  w_result = ~(in_a | in_b);
         3'b100:  w_result = ~(in_a & in_b);
         3'b101:  w_result = ~(in_a ^ in_b);
         3'b110:  w_result = in_a & ~in_b;
         default: w_result = in_a | ~in_b;
      endcase
   end

   // Flags are evaluated once at push and travel with the result, keeping
   // the wide reductions off the output path.
`ifdef LOGIC_UNIT_PARITY_EN
   assign w_entry = {^w_result, &w_result, ~|w_result, w_result};
`else
   assign w_entry = {&w_result, ~|w_result, w_result};
`endif

   // ---------------------------------------------------------------------
   // Handshake. in_ready depends only on registered occupancy, so a pop in
   // the same cycle never opens a full FIFO.
   // ---------------------------------------------------------------------
   assign in_ready  = (r_occ != c_full);
   assign out_valid = (r_occ != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + c_occ_w'(1);
            2'b01:   r_occ <= r_occ - c_occ_w'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Storage needs no reset: the outputs are masked while occupancy is zero.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // ---------------------------------------------------------------------
   // Head presentation, forced to zero when the FIFO is empty
   // ---------------------------------------------------------------------
   assign w_head     = r_mem[r_rd_ptr];
   assign out_result = out_valid ? w_head[WIDTH-1:0] : '0;
   assign out_zero   = out_valid & w_head[WIDTH];
   assign out_ones   = out_valid & w_head[WIDTH+1];
`ifdef LOGIC_UNIT_PARITY_EN
   assign out_parity = out_valid & w_head[WIDTH+2];
`endif
   assign occupancy  = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Self-checking bench for logic_unit_pipe (WIDTH=32, DEPTH=2).
//            A queue-based reference model tracks accepted results; a
//            negedge compare process checks every output every cycle, and
//            directed sections pin literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b0;
   logic [2:0]       in_op     = 3'd0;
   logic [WIDTH-1:0] in_a      = '0;
   logic [WIDTH-1:0] in_b      = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_ones;
`ifdef LOGIC_UNIT_PARITY_EN
   logic             out_parity;
`endif
   logic [$clog2(DEPTH+1)-1:0] occupancy;

   logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_ones   (out_ones),
`ifdef LOGIC_UNIT_PARITY_EN
      .out_parity (out_parity),
`endif
      .occupancy  (occupancy)
   );

   always #5 clk = ~clk;

   int  n_cmp  = 0;
   int  n_err  = 0;
   bit  chk_en = 1'b0;

   // Truth tables indexed by {a_bit, b_bit}.
   logic [3:0] tt_tab [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0001,
                              4'b0111, 4'b1001, 4'b0100, 4'b1101};

   logic [WIDTH-1:0] model_q [$];

   function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      logic [3:0]       tt;
      tt = tt_tab[op];
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = tt[{a[i], b[i]}];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: acceptance decided from the pre-edge queue size.
   bit m_push, m_pop;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_q.delete();
      end else begin
         m_push = in_valid && (model_q.size() != DEPTH);
         m_pop  = out_ready && (model_q.size() != 0);
         if (m_pop)  void'(model_q.pop_front());
         if (m_push) model_q.push_back(ref_fn(in_op, in_a, in_b));
      end
   end

   // Every-cycle comparison against the model.
   int               c_sz;
   logic [WIDTH-1:0] c_head;
   always @(negedge clk) begin
      if (chk_en) begin
         c_sz   = model_q.size();
         c_head = (c_sz != 0) ? model_q[0] : '0;
         check("occupancy", 32'(occupancy), 32'(c_sz));
         check("in_ready",  32'(in_ready),  32'(c_sz != DEPTH));
         check("out_valid", 32'(out_valid), 32'(c_sz != 0));
         check("out_result", out_result, c_head);
         check("out_zero",  32'(out_zero),  32'((c_sz != 0) && (c_head == '0)));
         check("out_ones",  32'(out_ones),  32'((c_sz != 0) && (c_head == '1)));
`ifdef LOGIC_UNIT_PARITY_EN
         check("out_parity", 32'(out_parity), 32'((c_sz != 0) && (^c_head)));
`endif
      end
   end

   logic [31:0] lits [8] = '{32'hF000_000F, 32'hFFF0_0FFF, 32'h0FF0_0FF0,
                             32'h000F_F000, 32'h0FFF_FFF0, 32'hF00F_F00F,
                             32'h00F0_00F0, 32'hF0FF_F0FF};

   initial begin
      // ---------------- reset / idle ----------------
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_out_result", out_result,    32'd0);
      @(negedge clk); #1 rst_n = 1'b1; chk_en = 1'b1;
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      #1;

      // ---------------- all opcodes ----------------
      out_ready = 1'b1;
      in_a = 32'hF0F0_00FF; in_b = 32'hFF00_0F0F;
      for (int op = 0; op < 8; op++) begin
         in_valid = 1'b1; in_op = 3'(op);
         @(negedge clk);
         check($sformatf("op%0d_result", op), out_result, lits[op]);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk); #1;

      // ---------------- flags ----------------
      in_valid = 1'b1; in_op = 3'b011; in_a = '0; in_b = '0;
      @(negedge clk);
      check("nor_result", out_result, 32'hFFFF_FFFF);
      check("nor_ones", 32'(out_ones), 32'd1);
      check("nor_zero", 32'(out_zero), 32'd0);
      #1 in_op = 3'b000; in_a = 32'h1234_5678; in_b = '0;
      @(negedge clk);
      check("and_zero", 32'(out_zero), 32'd1);
      #1 in_op = 3'b010; in_a = 32'h5; in_b = 32'h2;
      @(negedge clk);
      check("xor_result", out_result, 32'h7);
`ifdef LOGIC_UNIT_PARITY_EN
      check("xor_parity", 32'(out_parity), 32'd1);
`endif
      #1 in_valid = 1'b0;
      @(negedge clk); #1;

      // ---------------- backpressure / full ----------------
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'b001; in_b = '0; in_a = 32'h1;
      @(negedge clk);
      check("bp_occ1", 32'(occupancy), 32'd1);
      #1 in_a = 32'h2;
      @(negedge clk);
      check("bp_occ2", 32'(occupancy), 32'd2);
      check("bp_full_ready", 32'(in_ready), 32'd0);
      #1 in_a = 32'h3;
      @(negedge clk);
      check("bp_ignored_occ", 32'(occupancy), 32'd2);
      check("bp_head1", out_result, 32'h1);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("bp_head2", out_result, 32'h2);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      #1;
      @(negedge clk);
      check("bp_head3", out_result, 32'h3);
      check("bp_occ_after", 32'(occupancy), 32'd1);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("bp_drained", 32'(occupancy), 32'd0);
      #1;

      // ---------------- simultaneous push/pop across wrap ----------------
      out_ready = 1'b0; in_valid = 1'b1; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom;
      @(negedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_op = 3'($urandom); in_a = $urandom; in_b = $urandom;
         @(negedge clk);
         check("wrap_occ", 32'(occupancy), 32'd1);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk); #1;

      // ---------------- randomized traffic ----------------
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_op     = 3'($urandom);
         case ($urandom_range(3))
            0:       in_a = '0;
            1:       in_a = '1;
            default: in_a = $urandom;
         endcase
         case ($urandom_range(3))
            0:       in_b = '0;
            1:       in_b = '1;
            default: in_b = $urandom;
         endcase
         @(negedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) begin @(negedge clk); #1; end

      // ---------------- reset mid-stream ----------------
      out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b001; in_b = '0; in_a = 32'hA;
      @(negedge clk); #1 in_a = 32'hB;
      @(negedge clk);
      check("mid_occ2", 32'(occupancy), 32'd2);
      #3 rst_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_in_ready",  32'(in_ready),  32'd1);
      check("mid_occ0",      32'(occupancy), 32'd0);
      in_valid = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_valid", 32'(out_valid), 32'd0);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
